issue_queue: RTL

//  Out-of-order issue queue directly downstream of the dispatch queue. Accepts up to

---
 rtl/issue_queue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// Out-of-order issue queue: compacting storage, oldest-first select,
// writeback wakeup with same-cycle bypass for entries being enqueued.

// Per-source wakeup: source becomes ready on any matching writeback tag.
module issue_queue_wake #(
   parameter int WB_WIDTH = 2,
   parameter int PREG_W   = 6
) (
   input  logic [PREG_W-1:0]          i_tag,
   input  logic                       i_rdy,
   input  logic [WB_WIDTH-1:0]        i_wb_valid,
   input  logic [WB_WIDTH*PREG_W-1:0] i_wb_pdest,
   output logic                       o_rdy
);
   // OR of the stored ready bit with every valid, tag-matching writeback port
   always_comb begin
      o_rdy = i_rdy;
      for (int p = 0; p < WB_WIDTH; p++)
         if (i_wb_valid[p] && (i_wb_pdest[p*PREG_W +: PREG_W] == i_tag)) o_rdy = 1'b1;
   end
endmodule

module issue_queue #(
   parameter int DEPTH          = 8,
   parameter int DISPATCH_WIDTH = 2,
   parameter int WB_WIDTH       = 2,
   parameter int PREG_W         = 6,
   parameter int PAYLOAD_W      = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush_i,
   input  logic [DISPATCH_WIDTH-1:0]           enq_valid_i,
   input  logic [DISPATCH_WIDTH*PREG_W-1:0]    enq_src0_i,
   input  logic [DISPATCH_WIDTH*PREG_W-1:0]    enq_src1_i,
   input  logic [DISPATCH_WIDTH-1:0]           enq_rdy0_i,
   input  logic [DISPATCH_WIDTH-1:0]           enq_rdy1_i,
   input  logic [DISPATCH_WIDTH*PREG_W-1:0]    enq_pdest_i,
   input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] enq_payload_i,
   output logic                                enq_ready_o,
   output logic                                iss_valid_o,
   output logic [PREG_W-1:0]                   iss_pdest_o,
   output logic [PAYLOAD_W-1:0]                iss_payload_o,
   input  logic                                iss_ready_i,
   input  logic [WB_WIDTH-1:0]                 wb_valid_i,
   input  logic [WB_WIDTH*PREG_W-1:0]          wb_pdest_i,
   output logic [$clog2(DEPTH+1)-1:0]          count_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = DISPATCH_WIDTH;

   // Slot i holds a valid entry iff i < r_count; slot 0 is the oldest.
   logic [CW-1:0]                       r_count;
   logic [DEPTH-1:0][PREG_W-1:0]        r_src0, r_src1, r_pdest;
   logic [DEPTH-1:0]                    r_rdy0, r_rdy1;
   logic [DEPTH-1:0][PAYLOAD_W-1:0]     r_pay;

   logic [DEPTH-1:0]                    w_wk0, w_wk1;
   logic [DW-1:0]                       w_lrdy0, w_lrdy1;
   logic                                w_found, w_fire;
   logic [SW-1:0]                       w_sel;
   logic [CW-1:0]                       w_rem, w_pos;
   logic [DEPTH-1:0][PREG_W-1:0]        w_src0_up, w_src1_up, w_pdest_up;
   logic [DEPTH-1:0][PAYLOAD_W-1:0]     w_pay_up;
   logic [DEPTH-1:0]                    w_rdy0_up, w_rdy1_up;
   logic [DEPTH-1:0][PREG_W-1:0]        w_nsrc0, w_nsrc1, w_npdest;
   logic [DEPTH-1:0][PAYLOAD_W-1:0]     w_npay;
   logic [DEPTH-1:0]                    w_nrdy0, w_nrdy1;

   // Wakeup of stored entries and bypass wakeup of incoming lanes
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      issue_queue_wake #(.WB_WIDTH(WB_WIDTH), .PREG_W(PREG_W)) u_wk0 (
         .i_tag(r_src0[g]), .i_rdy(r_rdy0[g]), .i_wb_valid(wb_valid_i),
         .i_wb_pdest(wb_pdest_i), .o_rdy(w_wk0[g]));
      issue_queue_wake #(.WB_WIDTH(WB_WIDTH), .PREG_W(PREG_W)) u_wk1 (
         .i_tag(r_src1[g]), .i_rdy(r_rdy1[g]), .i_wb_valid(wb_valid_i),
         .i_wb_pdest(wb_pdest_i), .o_rdy(w_wk1[g]));
   end
   for (genvar g = 0; g < DW; g++) begin : g_lane
      issue_queue_wake #(.WB_WIDTH(WB_WIDTH), .PREG_W(PREG_W)) u_wk0 (
         .i_tag(enq_src0_i[g*PREG_W +: PREG_W]), .i_rdy(enq_rdy0_i[g]),
         .i_wb_valid(wb_valid_i), .i_wb_pdest(wb_pdest_i), .o_rdy(w_lrdy0[g]));
      issue_queue_wake #(.WB_WIDTH(WB_WIDTH), .PREG_W(PREG_W)) u_wk1 (
         .i_tag(enq_src1_i[g*PREG_W +: PREG_W]), .i_rdy(enq_rdy1_i[g]),
         .i_wb_valid(wb_valid_i), .i_wb_pdest(wb_pdest_i), .o_rdy(w_lrdy1[g]));
   end

   assign enq_ready_o = (CW'(DEPTH) - r_count) >= CW'(DW);
   assign count_o     = r_count;

   // Oldest-ready select: scan downward so the lowest ready slot wins
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if ((i < int'(r_count)) && r_rdy0[i] && r_rdy1[i]) begin
            w_found = 1'b1;
            w_sel   = SW'(i);
         end
   end

   assign iss_valid_o   = w_found;
   assign iss_pdest_o   = w_found ? r_pdest[w_sel] : '0;
   assign iss_payload_o = w_found ? r_pay[w_sel]   : '0;
   assign w_fire        = w_found & iss_ready_i;

   // Next state: collapse the issued slot, then append fired lanes in lane order
   always_comb begin
      w_rem      = r_count - CW'(w_fire);
      w_src0_up  = r_src0  >> PREG_W;
      w_src1_up  = r_src1  >> PREG_W;
      w_pdest_up = r_pdest >> PREG_W;
      w_pay_up   = r_pay   >> PAYLOAD_W;
      w_rdy0_up  = w_wk0   >> 1;
      w_rdy1_up  = w_wk1   >> 1;
      w_nsrc0    = '0;
      w_nsrc1    = '0;
      w_npdest   = '0;
      w_npay     = '0;
      w_nrdy0    = '0;
      w_nrdy1    = '0;
      for (int j = 0; j < DEPTH; j++) begin
         if (j < int'(w_rem)) begin
            if (w_fire && (j >= int'(w_sel))) begin
               w_nsrc0[j]  = w_src0_up[j];
               w_nsrc1[j]  = w_src1_up[j];
               w_npdest[j] = w_pdest_up[j];
               w_npay[j]   = w_pay_up[j];
               w_nrdy0[j]  = w_rdy0_up[j];
               w_nrdy1[j]  = w_rdy1_up[j];
            end else begin
               w_nsrc0[j]  = r_src0[j];
               w_nsrc1[j]  = r_src1[j];
               w_npdest[j] = r_pdest[j];
               w_npay[j]   = r_pay[j];
               w_nrdy0[j]  = w_wk0[j];
               w_nrdy1[j]  = w_wk1[j];
            end
         end
      end
      w_pos = w_rem;
      for (int l = 0; l < DW; l++) begin
         if (enq_valid_i[l] && enq_ready_o) begin
            for (int j = 0; j < DEPTH; j++)
               if (j == int'(w_pos)) begin
                  w_nsrc0[j]  = enq_src0_i[l*PREG_W +: PREG_W];
                  w_nsrc1[j]  = enq_src1_i[l*PREG_W +: PREG_W];
                  w_npdest[j] = enq_pdest_i[l*PREG_W +: PREG_W];
                  w_npay[j]   = enq_payload_i[l*PAYLOAD_W +: PAYLOAD_W];
                  w_nrdy0[j]  = w_lrdy0[l];
                  w_nrdy1[j]  = w_lrdy1[l];
               end
            w_pos = w_pos + 1'b1;
         end
      end
   end

   // State update; reset and flush both empty the queue
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_count <= '0;
         r_src0  <= '0;
         r_src1  <= '0;
         r_pdest <= '0;
         r_pay   <= '0;
         r_rdy0  <= '0;
         r_rdy1  <= '0;
      end else begin
         r_count <= w_pos;
         r_src0  <= w_nsrc0;
         r_src1  <= w_nsrc1;
         r_pdest <= w_npdest;
         r_pay   <= w_npay;
         r_rdy0  <= w_nrdy0;
         r_rdy1  <= w_nrdy1;
      end
   end
endmodule
